// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences each instruction
// through 2-5 states, drives every datapath strobe and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             Zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       RegDst,
    output logic             Mem2Reg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             ExS,
    output logic [3:0]       State,
    output logic             Retire,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
        StMemWb   = 4'd4,  StMemWr  = 4'd5,  StRex    = 4'd6,  StRwb    = 4'd7,
        StBranch  = 4'd8,  StIex    = 4'd9,  StIwb    = 4'd10, StJmp    = 4'd11,
        StJal1    = 4'd12, StJal2   = 4'd13, StJr     = 4'd14, StIllegal = 4'd15
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000, OpJ    = 6'b000010, OpJal  = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100, OpBne  = 6'b000101, OpLw   = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011, FuncJr = 6'b001000;

    localparam logic [3:0] AluAnd = 4'b0000, AluOr  = 4'b0001, AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011, AluNor = 4'b0100, AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111, AluSll = 4'b1000, AluSrl = 4'b1001;
    localparam logic [3:0] AluSra = 4'b1010, AluLui = 4'b1011, AluPassA = 4'b1100;

    // Register is plain logic so an illegal code can exist in it and be recovered from.
    logic [3:0]       state_q;
    state_e           state_d;
    logic [CNT_W-1:0] instr_count_q;

    logic       r_ok, i_ok, i_exs;
    logic [3:0] r_alu, i_alu;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = AluAdd;
        casez (func)
            6'b10000?: r_alu = AluAdd;
            6'b10001?: r_alu = AluSub;
            6'b100100: r_alu = AluAnd;
            6'b100101: r_alu = AluOr;
            6'b100110: r_alu = AluXor;
            6'b100111: r_alu = AluNor;
            6'b101010: r_alu = AluSlt;
            6'b000000: r_alu = AluSll;
            6'b000010: r_alu = AluSrl;
            6'b000011: r_alu = AluSra;
            default:   r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_ok  = 1'b1;
        i_alu = AluAdd;
        i_exs = 1'b1;
        case (op)
            6'b001000, 6'b001001: i_alu = AluAdd;
            6'b001010: i_alu = AluSlt;
            6'b001100: begin i_alu = AluAnd; i_exs = 1'b0; end
            6'b001101: begin i_alu = AluOr;  i_exs = 1'b0; end
            6'b001110: begin i_alu = AluXor; i_exs = 1'b0; end
            6'b001111: begin i_alu = AluLui; i_exs = 1'b0; end
            default:   i_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = StFetch;
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 2'd0;
        Mem2Reg    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUControl = AluAdd;
        PCSrc      = 2'd0;
        ExS        = 1'b1;
        unique case (state_q)
            StFetch: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'd1;
                PCEn    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = 2'd3;
                case (op)
                    OpLw, OpSw:   state_d = StMemAdr;
                    OpRtype:      state_d = (func == FuncJr) ? StJr : (r_ok ? StRex : StFetch);
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJmp;
                    OpJal:        state_d = StJal1;
                    default:      state_d = i_ok ? StIex : StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                IorD    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                Mem2Reg  = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StRex: begin
                ALUSrcA    = 1'b1;
                ALUControl = r_alu;
                state_d    = StRwb;
            end
            StRwb: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            StIex, StIwb: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ALUControl = i_alu;
                ExS        = i_exs;
                RegWrite   = (state_q == StIwb);
                state_d    = (state_q == StIex) ? StIwb : StFetch;
            end
            StBranch: begin
                ALUSrcA    = 1'b1;
                ALUControl = AluSub;
                PCSrc      = 2'd1;
                PCEn       = Zero ^ op[0];  // beq takes on Zero, bne on !Zero
            end
            StJmp: begin
                PCSrc = 2'd2;
                PCEn  = 1'b1;
            end
            StJal1: begin
                ALUControl = AluPassA;
                state_d    = StJal2;
            end
            StJal2: begin
                RegDst   = 2'd2;
                RegWrite = 1'b1;
                PCSrc    = 2'd2;
                PCEn     = 1'b1;
            end
            StJr: begin
                ALUSrcA    = 1'b1;
                ALUControl = AluPassA;
                PCEn       = 1'b1;
            end
            StIllegal: state_d = StFetch;
        endcase
        Retire = (state_d == StFetch) && (state_q != StIllegal);
        // Reset aborts the instruction in flight: nothing may commit on this cycle.
        if (Reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Retire   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= StFetch;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (Retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

    assign State      = state_q;
    assign InstrCount = instr_count_q;

endmodule
